// File: rtl/mptw_issue_stage.sv
// rtl/mptw_issue_stage.sv - MPT walker front-end issuer with credits, in-order response FIFO and BARE bypass
//
// mptw_issue_pkg: MMPT register layout, walker transaction format and fault codes.
//
// mptw_issue_stage ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         client check request handshake
//   req_spa_i, req_access_i         address to check and access type (0 R, 1 W, 2 X, 3 reserved)
//   mmpt_i                          live MMPT CSR value, snapshotted on acceptance
//   issue_master_valid_o/ready_i    transaction handshake toward the fetch stage
//   issue_master_wdata_o            packed mptw_transaction_t {mmpt, spa, access}
//   rsp_valid_i, rsp_allow_i,
//   rsp_fault_i                     completion from the pipeline tail (no backpressure)
//   resp_valid_o/resp_ready_i       client response handshake
//   resp_allow_o, resp_fault_o      response verdict and fault cause
//   busy_o                          checks outstanding or FSM not idle
//   error_o                         sticky spurious-completion flag

package mptw_issue_pkg;

    typedef enum logic [3:0] {
        BARE_MODE    = 4'd0,
        SMMPT34_MODE = 4'd1,
        SMMPT43_MODE = 4'd2,
        SMMPT52_MODE = 4'd3,
        SMMPT64_MODE = 4'd4
    } mmpt_mode_e;

    typedef struct packed {
        logic [3:0]  mode;
        logic [1:0]  rsvd_hi;
        logic [5:0]  sdid;
        logic [7:0]  rsvd_lo;
        logic [43:0] ppn;
    } mmpt_reg_t;

    typedef enum logic [2:0] {
        NO_ERROR           = 3'd0,
        MPTE_L3_INVALID    = 3'd1,
        MPTE_L2_INVALID    = 3'd2,
        MPTE_L1_INVALID    = 3'd3,
        MPTE_INVALID       = 3'd4,
        MPT_ILLEGAL_ACCESS = 3'd5,
        MPT_MODE_INVALID   = 3'd6,
        MPT_ACCESS_FAULT   = 3'd7
    } page_format_fault_e;

    // Physical addresses are at most 56 bits, so 62 bits of spa are carried;
    // this keeps the whole transaction at 128 bits.
    typedef struct packed {
        mmpt_reg_t  mmpt;
        logic [61:0] spa;
        logic [1:0]  access;
    } mptw_transaction_t;

endpackage

module mptw_issue_stage
    import mptw_issue_pkg::*;
#(
    parameter int PIPELINE_MASTER_DATA_WIDTH = 128,
    parameter int MAX_OUTSTANDING            = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [63:0]                           req_spa_i,
    input  logic [1:0]                            req_access_i,
    input  logic [63:0]                           mmpt_i,
    output logic                                  issue_master_valid_o,
    input  logic                                  issue_master_ready_i,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] issue_master_wdata_o,
    input  logic                                  rsp_valid_i,
    input  logic                                  rsp_allow_i,
    input  logic [2:0]                            rsp_fault_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_allow_o,
    output logic [2:0]                            resp_fault_o,
    output logic                                  busy_o,
    output logic                                  error_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_BYPASS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     credits_q;
    logic [CW-1:0]     fifo_count_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [3:0]        fifo_mem [MAX_OUTSTANDING];
    mptw_transaction_t txn_q;
    logic              error_q;

    mmpt_reg_t         mmpt_in;
    logic              is_bare;
    logic              accept;
    logic              fifo_empty;
    logic              resp_hs;
    logic              in_bypass;
    logic              bypass_push;
    logic [CW-1:0]     awaiting;
    logic              rsp_ok;
    logic              spurious;
    logic              push;
    logic [3:0]        push_data;
    logic [3:0]        head;
    logic [1:0]        spa_hi_unused;

    assign mmpt_in       = mmpt_i;
    assign spa_hi_unused = req_spa_i[63:62];
    assign is_bare       = (mmpt_in.mode == BARE_MODE);

    // BARE answers jump the pipeline, so they wait until nothing is in flight
    // to keep responses in request order.
    assign req_ready_o = (state_q == S_IDLE) && (credits_q < CREDIT_MAX)
                         && (!is_bare || (credits_q == '0));
    assign accept      = req_valid_i && req_ready_o;

    assign fifo_empty  = (fifo_count_q == '0);
    assign resp_hs     = !fifo_empty && resp_ready_i;
    assign in_bypass   = (state_q == S_BYPASS);

    // Pipeline checks still owed a result: credits minus what is already queued,
    // minus the credit held by a BARE request that never entered the pipeline.
    assign awaiting  = credits_q - fifo_count_q - CW'(in_bypass);
    assign rsp_ok    = rsp_valid_i && (awaiting != '0);
    assign spurious  = rsp_valid_i && (awaiting == '0);

    // In BYPASS every credit is the bypass itself, so rsp_ok cannot coincide.
    assign push      = bypass_push || rsp_ok;
    assign push_data = bypass_push ? {1'b1, NO_ERROR} : {rsp_allow_i, rsp_fault_i};

    assign head         = fifo_mem[rd_ptr_q];
    assign resp_valid_o = !fifo_empty;
    assign resp_allow_o = !fifo_empty && head[3];
    assign resp_fault_o = fifo_empty ? 3'd0 : head[2:0];

    assign issue_master_wdata_o = txn_q;
    assign busy_o               = (credits_q != '0) || (state_q != S_IDLE);
    assign error_o              = error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        issue_master_valid_o = 1'b0;
        bypass_push          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_bare ? S_BYPASS : S_SEND;
                end
            end
            S_SEND: begin
                issue_master_valid_o = 1'b1;
                if (issue_master_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_BYPASS: begin
                bypass_push = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Issue register only loads in IDLE, so it is stable for the whole of SEND.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_q <= '0;
        end else if (accept) begin
            txn_q <= {mmpt_in, req_spa_i[61:0], req_access_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
        end else begin
            case ({accept, resp_hs})
                2'b10:   credits_q <= credits_q + CW'(1);
                2'b01:   credits_q <= credits_q - CW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (resp_hs) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, resp_hs})
                2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else if (spurious) begin
            error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mptw_issue_stage.sv
// tb/tb_mptw_issue_stage.sv - self-checking bench for mptw_issue_stage
module tb_mptw_issue_stage;
    import mptw_issue_pkg::*;

    localparam int W    = 128;
    localparam int MAXO = 4;
    localparam logic [3:0] MB  = 4'd0;
    localparam logic [3:0] M43 = 4'd2;
    localparam logic [59:0] MMPT_LO = 60'h0AB_CDEF_0123_4567;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_spa;
    logic [1:0]   req_access;
    logic [63:0]  mmpt;
    logic         issue_valid;
    logic         issue_ready;
    logic [W-1:0] issue_wdata;
    logic         rsp_valid;
    logic         rsp_allow;
    logic [2:0]   rsp_fault;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_allow;
    logic [2:0]   resp_fault;
    logic         busy;
    logic         error;

    always #5 clk = ~clk;

    mptw_issue_stage #(
        .PIPELINE_MASTER_DATA_WIDTH(W),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_spa_i            (req_spa),
        .req_access_i         (req_access),
        .mmpt_i               (mmpt),
        .issue_master_valid_o (issue_valid),
        .issue_master_ready_i (issue_ready),
        .issue_master_wdata_o (issue_wdata),
        .rsp_valid_i          (rsp_valid),
        .rsp_allow_i          (rsp_allow),
        .rsp_fault_i          (rsp_fault),
        .resp_valid_o         (resp_valid),
        .resp_ready_i         (resp_ready),
        .resp_allow_o         (resp_allow),
        .resp_fault_o         (resp_fault),
        .busy_o               (busy),
        .error_o              (error)
    );

    typedef struct {
        logic        rv;
        logic [3:0]  mode;
        logic [63:0] spa;
        logic [1:0]  acc;
        logic        ir;
        logic        rspv;
        logic        rspa;
        logic [2:0]  rspf;
        logic        rr;
        logic        e_rdy;
        logic        e_iv;
        logic        e_rvo;
        logic        e_ra;
        logic [2:0]  e_rf;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic iv, input logic rvo,
                            input logic ra, input logic [2:0] rf, input logic bsy, input logic err);
        chk({tag, ".req_ready"},  W'(req_ready),   W'(rdy));
        chk({tag, ".issue_valid"}, W'(issue_valid), W'(iv));
        chk({tag, ".resp_valid"}, W'(resp_valid),  W'(rvo));
        chk({tag, ".resp_allow"}, W'(resp_allow),  W'(ra));
        chk({tag, ".resp_fault"}, W'(resp_fault),  W'(rf));
        chk({tag, ".busy"},       W'(busy),        W'(bsy));
        chk({tag, ".error"},      W'(error),       W'(err));
    endtask

    task automatic drive(input logic rv, input logic [3:0] mode_v, input logic [63:0] spa,
                         input logic [1:0] acc, input logic ir, input logic rspv,
                         input logic rspa, input logic [2:0] rspf, input logic rr);
        req_valid   = rv;
        mmpt        = {mode_v, MMPT_LO};
        req_spa     = spa;
        req_access  = acc;
        issue_ready = ir;
        rsp_valid   = rspv;
        rsp_allow   = rspa;
        rsp_fault   = rspf;
        resp_ready  = rr;
    endtask

    task automatic add(input logic rv, input logic [3:0] mode_v, input logic [63:0] spa,
                       input logic [1:0] acc, input logic ir, input logic rspv, input logic rspa,
                       input logic [2:0] rspf, input logic rr, input logic e_rdy, input logic e_iv,
                       input logic e_rvo, input logic e_ra, input logic [2:0] e_rf,
                       input logic e_busy, input logic e_err);
        vec_t v;
        v = '{rv, mode_v, spa, acc, ir, rspv, rspa, rspf, rr,
              e_rdy, e_iv, e_rvo, e_ra, e_rf, e_busy, e_err};
        vq.push_back(v);
    endtask

    function automatic logic [W-1:0] txn_of(input logic [3:0] mode_v, input logic [63:0] spa,
                                             input logic [1:0] acc);
        return {mode_v, MMPT_LO, spa[61:0], acc};
    endfunction

    // reference model state for the random phase
    int          m_credits;
    int          m_pipe;
    int          m_await;
    bit          m_pend_issue;
    bit          m_pend_byp;
    bit          m_err;
    logic [W-1:0] m_data;
    logic [3:0]  m_rq[$];

    initial begin
        logic [W-1:0] exp_txn;
        exp_txn = '0;
        drive(0, M43, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //   rv mode spa        acc ir rspv ra rf rr | rdy iv rvo ra rf busy err
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 0 reset state
        add(1, M43, 64'h1000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 1 accept
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0); // 2 stall
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0); // 3
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0); // 4
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0); // 5 handshake
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0); // 6
        add(0, M43, 64'h0,    0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0); // 7 completion
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 1, 0); // 8 pop
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 9
        add(1, MB,  64'h7000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 10 BARE accept
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0); // 11 bypass
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 1, 0); // 12 resp N+2
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 1, 0); // 13 pop
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 14
        add(1, M43, 64'h2000, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 15 req 1
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0); // 16
        add(1, M43, 64'h3000, 1, 1, 1, 0, 3, 0,  1, 0, 0, 0, 0, 1, 0); // 17 req 2
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 3, 1, 0); // 18
        add(1, M43, 64'h4000, 2, 1, 1, 1, 5, 0,  1, 0, 1, 0, 3, 1, 0); // 19 req 3
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 3, 1, 0); // 20
        add(1, M43, 64'h5000, 3, 1, 1, 0, 6, 0,  1, 0, 1, 0, 3, 1, 0); // 21 req 4
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 3, 1, 0); // 22
        add(1, M43, 64'h6000, 0, 1, 1, 1, 2, 0,  0, 0, 1, 0, 3, 1, 0); // 23 credits full
        add(1, M43, 64'h6000, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 3, 1, 0); // 24
        add(1, M43, 64'h6000, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 3, 1, 0); // 25 pop
        add(1, M43, 64'h6000, 0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 5, 1, 0); // 26 credit freed
        add(0, M43, 64'h0,    0, 1, 0, 0, 0, 1,  0, 1, 1, 1, 5, 1, 0); // 27
        add(0, M43, 64'h0,    0, 1, 1, 0, 7, 1,  1, 0, 1, 0, 6, 1, 0); // 28 push+pop at 2
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 2, 1, 0); // 29
        add(1, MB,  64'h9000, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 7, 1, 0); // 30 BARE held
        add(1, MB,  64'h9000, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 7, 1, 0); // 31 pop last
        add(1, MB,  64'h9000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 32 BARE accept
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0); // 33
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 1, 0); // 34
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 1, 0); // 35
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // 36
        add(0, M43, 64'h0,    0, 0, 1, 1, 4, 0,  1, 0, 0, 0, 0, 0, 0); // 37 spurious
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1); // 38
        add(0, M43, 64'h0,    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1); // 39 sticky

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rv, vq[i].mode, vq[i].spa, vq[i].acc, vq[i].ir,
                  vq[i].rspv, vq[i].rspa, vq[i].rspf, vq[i].rr);
            #1;
            chk_outs($sformatf("row%0d", i), vq[i].e_rdy, vq[i].e_iv, vq[i].e_rvo,
                     vq[i].e_ra, vq[i].e_rf, vq[i].e_busy, vq[i].e_err);
            if (vq[i].e_iv)
                chk($sformatf("row%0d.wdata", i), issue_wdata, exp_txn);
            if (vq[i].rv && vq[i].e_rdy)
                exp_txn = txn_of(vq[i].mode, vq[i].spa, vq[i].acc);
            @(negedge clk);
        end

        // asynchronous reset in the middle of SEND
        drive(1, M43, 64'h8000, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, M43, 64'h0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst.pre_issue_valid", W'(issue_valid), W'(1'b1));
        chk("rst.pre_wdata", issue_wdata, txn_of(M43, 64'h8000, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst", 1, 0, 0, 0, 0, 0, 0);
        chk("rst.wdata", issue_wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized phase against the reference model
        m_credits = 0; m_pipe = 0; m_pend_issue = 0; m_pend_byp = 0; m_err = 0;
        m_data = '0;
        m_rq.delete();
        for (int c = 0; c < 1500; c++) begin
            logic       rv, ir, rspv, rspa, rr, bare, e_rdy, e_rvo, e_ra;
            logic [3:0] mode_v;
            logic [2:0] rspf, e_rf;
            logic [63:0] spa;
            logic [1:0] acc;
            rv     = 1'($urandom % 2);
            mode_v = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(1, 7));
            spa    = {$urandom, $urandom};
            acc    = 2'($urandom);
            ir     = 1'($urandom % 2);
            rspv   = (m_pipe > 0) && ($urandom % 3 == 0);
            rspa   = 1'($urandom);
            rspf   = 3'($urandom);
            rr     = 1'($urandom % 2);
            drive(rv, mode_v, spa, acc, ir, rspv, rspa, rspf, rr);
            #1;
            bare  = (mode_v == 4'd0);
            e_rdy = !m_pend_issue && !m_pend_byp && (m_credits < MAXO)
                    && (!bare || m_credits == 0);
            e_rvo = (m_rq.size() > 0);
            e_ra  = e_rvo ? m_rq[0][3] : 1'b0;
            e_rf  = e_rvo ? m_rq[0][2:0] : 3'd0;
            chk_outs($sformatf("rnd%0d", c), e_rdy, m_pend_issue, e_rvo, e_ra, e_rf,
                     (m_credits > 0) || m_pend_issue || m_pend_byp, m_err);
            if (m_pend_issue)
                chk($sformatf("rnd%0d.wdata", c), issue_wdata, m_data);

            m_await = m_credits - m_rq.size() - int'(m_pend_byp);
            if (e_rvo && rr) begin
                void'(m_rq.pop_front());
                m_credits--;
            end
            if (m_pend_byp) begin
                m_rq.push_back(4'b1000);
                m_pend_byp = 0;
            end
            if (rspv) begin
                if (m_await > 0) m_rq.push_back({rspa, rspf});
                else m_err = 1;
                m_pipe--;
            end
            if (m_pend_issue && ir) begin
                m_pend_issue = 0;
                m_pipe++;
            end
            if (rv && e_rdy) begin
                m_credits++;
                if (bare) m_pend_byp = 1;
                else begin
                    m_pend_issue = 1;
                    m_data = txn_of(mode_v, spa, acc);
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
